// File: rtl/lcd_pkg.sv
// Shared constants, encodings and address helpers for the HD44780 responder.
// Covers instruction masks, DDRAM line geometry and the responder FSM states.
package lcd_pkg;

  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE0_END  = 7'h27;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  localparam logic [6:0] LINE1_END  = 7'h67;

  localparam int LINE_LEN    = 40;
  localparam int DDRAM_CELLS = 80;
  localparam int CGRAM_CELLS = 64;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // The highest set bit of an instruction byte selects the instruction.
  localparam logic [7:0] OP_CLEAR = 8'h01;
  localparam logic [7:0] OP_HOME  = 8'h02;
  localparam logic [7:0] OP_ENTRY = 8'h04;
  localparam logic [7:0] OP_DISP  = 8'h08;
  localparam logic [7:0] OP_SHIFT = 8'h10;
  localparam logic [7:0] OP_FUNC  = 8'h20;
  localparam logic [7:0] OP_CGRAM = 8'h40;
  localparam logic [7:0] OP_DDRAM = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR
  } lcd_state_e;

  typedef enum logic [3:0] {
    I_NOP,
    I_CLEAR,
    I_HOME,
    I_ENTRY,
    I_DISP,
    I_SHIFT,
    I_FUNC,
    I_SET_CGRAM,
    I_SET_DDRAM
  } lcd_instr_e;

  function automatic lcd_instr_e decode_instr(input logic [7:0] d);
    if      ((d & OP_DDRAM) != 8'h00) return I_SET_DDRAM;
    else if ((d & OP_CGRAM) != 8'h00) return I_SET_CGRAM;
    else if ((d & OP_FUNC)  != 8'h00) return I_FUNC;
    else if ((d & OP_SHIFT) != 8'h00) return I_SHIFT;
    else if ((d & OP_DISP)  != 8'h00) return I_DISP;
    else if ((d & OP_ENTRY) != 8'h00) return I_ENTRY;
    else if ((d & OP_HOME)  != 8'h00) return I_HOME;
    else if ((d & OP_CLEAR) != 8'h00) return I_CLEAR;
    return I_NOP;
  endfunction

  function automatic logic ddram_valid(input logic [6:0] a);
    return (a <= LINE0_END) || ((a >= LINE1_BASE) && (a <= LINE1_END));
  endfunction

  // Packs the two 40-cell lines into one 80-entry array; line 1 follows line 0.
  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return a[6] ? 7'(a - LINE1_BASE + 7'(LINE_LEN)) : a;
  endfunction

endpackage

// File: rtl/lcd_hd44780_responder_if.sv
// LCD control strobes from the writer, plus the stored-only configuration
// (entry shift bit, function-set bits) reported back by the responder.
interface lcd_hd44780_responder_if;
  logic       LCD_EN;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       entry_shift;
  logic [2:0] func_set;

  modport master (output LCD_EN, LCD_RS, LCD_RW, input entry_shift, func_set);
  modport slave  (input LCD_EN, LCD_RS, LCD_RW, output entry_shift, func_set);
endinterface

// File: rtl/lcd_ac_step.sv
// Next address-counter value after a data access, including the CGRAM wrap
// and the DDRAM line-to-line wrap in both directions.
module lcd_ac_step
  import lcd_pkg::*;
(
  input  logic [6:0] ac,
  input  logic       cgram_sel,
  input  logic       inc,
  output logic [6:0] ac_next
);

  logic gap0;
  logic gap1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ac_next = ac;
    gap0    = (ac > LINE0_END) && (ac < LINE1_BASE);
    gap1    = ac > LINE1_END;
    if (cgram_sel) begin
      ac_next = {1'b0, inc ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1};
    end else if (inc) begin
      // Addresses parked in a gap continue at the start of the following line.
      if (ac == LINE0_END || gap0)      ac_next = LINE1_BASE;
      else if (ac == LINE1_END || gap1) ac_next = LINE0_BASE;
      else                              ac_next = ac + 7'd1;
    end else begin
      if (ac == LINE1_BASE || gap0)     ac_next = LINE0_END;
      else if (ac == LINE0_BASE || gap1) ac_next = LINE1_END;
      else                              ac_next = ac - 7'd1;
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780-compatible character LCD responder: decodes writer strobes, keeps
// DDRAM/CGRAM/AC, answers busy-flag and data reads, and exposes the 16x2 screen.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = 40,
  parameter int CLEAR_CYCLES = 100,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                          Clk,
  input  logic                          rst,
  lcd_hd44780_responder_if.slave        bus,
  inout  wire  [7:0]                    LCD_DATA,
  input  logic [4:0]                    dbg_pos,
  output logic [7:0]                    dbg_char,
  output logic                          busy,
  output logic [6:0]                    ac,
  output logic                          disp_on,
  output logic                          cgram_sel,
  output logic                          err_busy_wr
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  logic [SYNC_STAGES-1:0] en_sync;
  logic                   en_d;
  logic                   en_s;
  logic                   strobe;

  lcd_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             fill_on;
  logic [6:0]       fill_idx;
  logic             entry_id;
  logic             entry_s;
  logic [2:0]       func_bits;

  logic [7:0] ddram [DDRAM_CELLS];
  logic [7:0] cgram [CGRAM_CELLS];

  lcd_instr_e instr;
  logic       accept, wr_acc, data_wr, instr_wr, data_rd;
  logic       clr_start, exec_start;
  logic       fill_we, dd_we, cg_we;
  logic [6:0] dd_waddr;
  logic [7:0] dd_wdata;
  logic [7:0] mem_byte, rd_byte;
  logic [6:0] ac_next;
  logic [6:0] dbg_addr;

  // EN is asynchronous to Clk; RS/RW/DATA are held stable by the writer.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      en_sync <= '0;
      en_d    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      en_sync[0] <= bus.LCD_EN;
      for (int i = 1; i < SYNC_STAGES; i++) en_sync[i] <= en_sync[i-1];
      en_d <= en_sync[SYNC_STAGES-1];
    end
  end

  assign en_s   = en_sync[SYNC_STAGES-1];
  assign strobe = en_d && !en_s;

  always_comb begin
    instr      = decode_instr(LCD_DATA);
    accept     = strobe && (state == ST_IDLE);
    wr_acc     = accept && !bus.LCD_RW;
    data_wr    = wr_acc && bus.LCD_RS;
    instr_wr   = wr_acc && !bus.LCD_RS;
    data_rd    = accept && bus.LCD_RW && bus.LCD_RS;
    clr_start  = instr_wr && (instr == I_CLEAR || instr == I_HOME);
    exec_start = data_wr || data_rd || (instr_wr && instr != I_NOP && !clr_start);

    // Fill and data writes share the DDRAM port; they never coincide because
    // data writes are only accepted in IDLE.
    fill_we  = (state == ST_CLEAR) && fill_on;
    dd_we    = fill_we || (data_wr && !cgram_sel && ddram_valid(ac));
    dd_waddr = fill_we ? fill_idx : ddram_index(ac);
    dd_wdata = fill_we ? ASCII_SPACE : LCD_DATA;
    cg_we    = data_wr && cgram_sel;
  end

  lcd_ac_step u_ac_step (
    .ac        (ac),
    .cgram_sel (cgram_sel),
    .inc       (entry_id),
    .ac_next   (ac_next)
  );

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_CLEAR;
      busy        <= 1'b1;
      cnt         <= CLEAR_LOAD;
      fill_on     <= 1'b1;
      fill_idx    <= '0;
      ac          <= LINE0_BASE;
      cgram_sel   <= 1'b0;
      disp_on     <= 1'b0;
      entry_id    <= 1'b1;
      entry_s     <= 1'b0;
      func_bits   <= '0;
      err_busy_wr <= 1'b0;
    end else begin
      // A strobe landing on the last busy cycle still counts as a busy write.
      if (strobe && !bus.LCD_RW && state != ST_IDLE) err_busy_wr <= 1'b1;

      unique case (state)
        ST_IDLE: begin
          if (clr_start) begin
            state     <= ST_CLEAR;
            busy      <= 1'b1;
            cnt       <= CLEAR_LOAD;
            ac        <= LINE0_BASE;
            cgram_sel <= 1'b0;
            if (instr == I_CLEAR) begin
              fill_on  <= 1'b1;
              fill_idx <= '0;
              entry_id <= 1'b1;
            end
          end else if (exec_start) begin
            state <= ST_EXEC;
            busy  <= 1'b1;
            cnt   <= BUSY_LOAD;
          end

          if (data_wr || data_rd) ac <= ac_next;

          if (instr_wr) begin
            case (instr)
              I_ENTRY: begin
                entry_id <= LCD_DATA[1];
                entry_s  <= LCD_DATA[0];
              end
              I_DISP:      disp_on   <= LCD_DATA[2];
              I_FUNC:      func_bits <= LCD_DATA[4:2];
              I_SET_CGRAM: begin
                ac        <= {1'b0, LCD_DATA[5:0]};
                cgram_sel <= 1'b1;
              end
              I_SET_DDRAM: begin
                ac        <= LCD_DATA[6:0];
                cgram_sel <= 1'b0;
              end
              default: ;
            endcase
          end
        end

        ST_EXEC: begin
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_CLEAR: begin
          if (fill_on) begin
            fill_idx <= fill_idx + 7'd1;
            if (fill_idx == 7'(DDRAM_CELLS - 1)) fill_on <= 1'b0;
          end
          if (cnt == '0) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: memory arrays carry no reset; DDRAM is initialised by the fill and CGRAM is undefined.
  always_ff @(posedge Clk) begin
    if (dd_we) ddram[dd_waddr] <= dd_wdata;
    if (cg_we) cgram[ac[5:0]]  <= LCD_DATA;
  end

  always_comb begin
    mem_byte = ASCII_SPACE;
    if (cgram_sel)             mem_byte = cgram[ac[5:0]];
    else if (ddram_valid(ac))  mem_byte = ddram[ddram_index(ac)];
    rd_byte  = bus.LCD_RS ? mem_byte : {busy, ac};
    dbg_addr = {dbg_pos[4], 2'b00, dbg_pos[3:0]};
    dbg_char = ddram[ddram_index(dbg_addr)];
  end

  assign LCD_DATA        = (bus.LCD_RW && en_s) ? rd_byte : 8'hzz;
  assign bus.entry_shift = entry_s;
  assign bus.func_set    = func_bits;

endmodule
